// File: rtl/sd_sector_pixel_packer.sv
// Strips the 0xFE token and CRC from SD sector bytes and packs data big-endian into tagged RGB565 pixels.
// Latency: a pixel is visible at the FIFO head the cycle after its low byte is accepted.
// Backpressure: byte_ready drops in DATA while the pixel FIFO is full; pix_ready=0 holds the head and x/y.
module sd_sector_pixel_packer #(
  parameter int SECTOR_BYTES = 512,
  parameter int CRC_BYTES    = 2,
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 240,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock_50r,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        sector_start,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        frame_start,
  output logic        sector_done
);

  localparam int BCW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam int CCW = $clog2(CRC_BYTES + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = AW + 1;

  localparam logic [BCW-1:0] LAST_DATA = BCW'(SECTOR_BYTES - 1);
  localparam logic [CCW-1:0] LAST_CRC  = CCW'(CRC_BYTES - 1);
  localparam logic [8:0]     X_LAST    = 9'(H_PIXELS - 1);
  localparam logic [7:0]     Y_LAST    = 8'(V_PIXELS - 1);
  localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CRC} state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [CCW-1:0] crc_cnt_q, crc_cnt_d;
  logic           phase_lo_q, phase_lo_d;
  logic [7:0]     hold_q, hold_d;
  logic           sector_done_q, sector_done_d;
  logic [8:0]     pix_x_q, pix_x_d;
  logic [7:0]     pix_y_q, pix_y_d;

  logic [15:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic           fifo_full;
  logic           fifo_vld;
  logic           byte_acc;
  logic           push;
  logic [15:0]    push_dat;
  logic           pop;

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign fifo_vld   = (fifo_cnt_q != '0);
  // Only DATA can fill the FIFO; poll, token and CRC bytes are always taken.
  assign byte_ready = (state_q != ST_DATA) | ~fifo_full;
  assign byte_acc   = byte_valid & byte_ready;
  assign pop        = fifo_vld & pix_ready;

  // Sector framing FSM: discard polls/token, pair data bytes hi-then-lo, count off the CRC.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    crc_cnt_d     = crc_cnt_q;
    phase_lo_d    = phase_lo_q;
    hold_d        = hold_q;
    sector_done_d = 1'b0;
    push          = 1'b0;
    push_dat      = {hold_q, byte_in};
    case (state_q)
      ST_IDLE: begin
        // Same-cycle byte is the 0xFE token and is dropped.
        if (sector_start) begin
          state_d    = ST_DATA;
          byte_cnt_d = '0;
          phase_lo_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (byte_acc) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (!phase_lo_q) begin
            hold_d     = byte_in;
            phase_lo_d = 1'b1;
          end else begin
            push       = 1'b1;
            phase_lo_d = 1'b0;
          end
          if (byte_cnt_q == LAST_DATA) begin
            state_d    = ST_CRC;
            byte_cnt_d = '0;
            crc_cnt_d  = '0;
          end
        end
      end
      ST_CRC: begin
        if (byte_acc) begin
          crc_cnt_d = crc_cnt_q + 1'b1;
          if (crc_cnt_q == LAST_CRC) begin
            state_d       = ST_IDLE;
            crc_cnt_d     = '0;
            sector_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel FIFO pointers; push never happens when full because byte_ready gates it.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fifo_cnt_d = fifo_cnt_q + FCW'(push) - FCW'(pop);
  end

  // Raster counters follow the head pixel and only advance on a pop.
  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (pop) begin
      if (pix_x_q == X_LAST) begin
        pix_x_d = '0;
        pix_y_d = (pix_y_q == Y_LAST) ? '0 : pix_y_q + 1'b1;
      end else begin
        pix_x_d = pix_x_q + 1'b1;
      end
    end
  end

  // State and control registers; reset drops any partial pixel and queued pixels.
  always_ff @(posedge clock_50r or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      crc_cnt_q     <= '0;
      phase_lo_q    <= 1'b0;
      hold_q        <= '0;
      sector_done_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      crc_cnt_q     <= crc_cnt_d;
      phase_lo_q    <= phase_lo_d;
      hold_q        <= hold_d;
      sector_done_q <= sector_done_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // FIFO storage needs no reset; validity comes from the count.
  always_ff @(posedge clock_50r) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign pix_valid   = fifo_vld;
  assign pix_data    = fifo_vld ? fifo_mem_q[rd_ptr_q] : '0;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fifo_vld & (pix_x_q == '0) & (pix_y_q == '0);
  assign sector_done = sector_done_q;

endmodule

// File: tb/tb_sd_sector_pixel_packer.sv
// Bench for sd_sector_pixel_packer: table of first-sector cycles, then directed multi-sector sequences.
// The frame is shortened to 4 lines so full-frame wrap is reachable in a short run.
module tb_sd_sector_pixel_packer;

  localparam int H  = 320;
  localparam int V  = 4;
  localparam int NX = 8192;

  logic        clock_50r = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        sector_start;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        frame_start;
  logic        sector_done;

  sd_sector_pixel_packer #(
    .SECTOR_BYTES(512), .CRC_BYTES(2), .H_PIXELS(H), .V_PIXELS(V), .FIFO_DEPTH(16)
  ) dut (
    .clock_50r(clock_50r), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .sector_start(sector_start), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .sector_done(sector_done)
  );

  always #5 clock_50r = ~clock_50r;

  int checks   = 0;
  int failures = 0;

  // Expected pixel stream: main process appends, monitor consumes.
  logic [15:0] exp_mem [NX];
  int          exp_wr = 0;
  int          exp_rd = 0;
  int          pix_n  = 0;
  int          sd_cnt = 0;
  int          fs_cnt = 0;
  int          pr_mode = 0;
  logic [7:0]  exp_hi;

  logic [8:0]  mon_x;
  logic [7:0]  mon_y;
  logic        mon_avail;
  logic [15:0] mon_dat;

  typedef struct packed {
    logic        bv;
    logic [7:0]  b;
    logic        ss;
    logic        pr;
    logic        rdy;
    logic        pv;
    logic [15:0] pd;
    logic [8:0]  x;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((i + seed * 37) & 255);
  endfunction

  // Pops happen at the next rising edge when valid & ready are seen at the falling edge.
  initial begin
    forever begin
      @(negedge clock_50r);
      if (reset) begin
        exp_rd = exp_wr;
        pix_n  = 0;
      end else begin
        if (sector_done) sd_cnt++;
        if (pix_valid && pix_ready) begin
          mon_x     = 9'(pix_n % H);
          mon_y     = 8'((pix_n / H) % V);
          mon_avail = (exp_rd < exp_wr);
          mon_dat   = mon_avail ? exp_mem[exp_rd % NX] : 16'h0;
          chk("pop", {mon_avail, pix_data, pix_x, pix_y, frame_start},
              {1'b1, mon_dat, mon_x, mon_y, (mon_x == 9'd0 && mon_y == 8'd0)});
          if (mon_avail) exp_rd++;
          if (frame_start) fs_cnt++;
          pix_n++;
        end
      end
    end
  end

  // pix_ready driver: 0 = hold off, 1 = always ready, other = random.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clock_50r);
      #2;
      case (pr_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  task automatic send_byte(input logic [7:0] b, input logic ss, input int gap);
    int t;
    if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clock_50r); #1; end
    byte_valid = 1'b1; byte_in = b; sector_start = ss;
    t = 0;
    while (!byte_ready && t < 2000) begin @(posedge clock_50r); #1; t++; end
    if (t >= 2000) chk("byte_ready_wait", 64'(t), 64'd0);
    @(posedge clock_50r); #1;
    byte_valid = 1'b0; sector_start = 1'b0;
  endtask

  task automatic send_data(input int seed, input int from, input int to, input int gap, input int ss_at);
    logic [7:0] b;
    for (int i = from; i <= to; i++) begin
      b = pat(seed, i);
      if (i % 2 == 0) exp_hi = b;
      else begin
        exp_mem[exp_wr % NX] = {exp_hi, b};
        exp_wr++;
      end
      send_byte(b, (i == ss_at), gap);
    end
  endtask

  task automatic send_crc(input int gap);
    send_byte(8'hC3, 1'b0, gap);
    send_byte(8'h3C, 1'b0, gap);
    chk("sector_done_pulse", 64'(sector_done), 64'd1);
    @(posedge clock_50r); #1;
    chk("sector_done_clear", 64'(sector_done), 64'd0);
  endtask

  task automatic send_sector(input int seed, input int gap, input int ss_at);
    send_byte(8'hFE, 1'b1, gap);
    send_data(seed, 0, 511, gap, ss_at);
    send_crc(gap);
  endtask

  task automatic wait_drain();
    int t;
    pr_mode = 1;
    t = 0;
    while ((pix_valid || exp_rd != exp_wr) && t < 3000) begin @(posedge clock_50r); #1; t++; end
    chk("drain", {pix_valid, 32'(exp_rd)}, {1'b0, 32'(exp_wr)});
  endtask

  initial begin
    int rd0;
    reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; sector_start = 1'b0;
    #1;
    chk("reset_outputs", {byte_ready, pix_valid, pix_data, pix_x, pix_y, frame_start, sector_done},
        {1'b1, 1'b0, 16'h0000, 9'd0, 8'd0, 1'b0, 1'b0});
    repeat (2) @(posedge clock_50r);
    #1 reset = 1'b0;
    @(posedge clock_50r); #1;

    // Test 1: polls, token, first pixels cycle by cycle, then the rest of the sector.
    for (int k = 0; k < 5; k++) tv[k] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd0};
    tv[5]  = '{1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd0};
    tv[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 9'd0};
    tv[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 9'd0};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 9'd0};
    tv[9]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 9'd0};
    tv[10] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0203, 9'd1};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 9'd2};
    exp_mem[0] = 16'h0001;
    exp_mem[1] = 16'h0203;
    exp_wr = 2;
    for (int k = 0; k < 12; k++) begin
      byte_valid = tv[k].bv; byte_in = tv[k].b; sector_start = tv[k].ss;
      pr_mode = tv[k].pr ? 1 : 0;
      @(posedge clock_50r); #1;
      chk($sformatf("vec%0d", k), {byte_ready, pix_valid, pix_data, pix_x},
          {tv[k].rdy, tv[k].pv, tv[k].pd, tv[k].x});
    end
    byte_valid = 1'b0; sector_start = 1'b0;
    send_data(0, 4, 511, 0, -1);
    send_crc(0);
    wait_drain();
    chk("t1_sector_done_count", 64'(sd_cnt), 64'd1);

    // Test 2: FIFO fills with the consumer stalled, then releases in order.
    pr_mode = 0;
    @(posedge clock_50r); #1;
    send_byte(8'hFE, 1'b1, 0);
    send_data(0, 0, 31, 0, -1);
    chk("t2_full_ready", 64'(byte_ready), 64'd0);
    chk("t2_full_head", {pix_valid, pix_data, pix_x, pix_y}, {1'b1, 16'h0001, 9'd256, 8'd0});
    repeat (5) @(posedge clock_50r);
    #1;
    chk("t2_stall_hold", {byte_ready, pix_x, pix_y}, {1'b0, 9'd256, 8'd0});
    pr_mode = 1;
    send_data(0, 32, 511, 0, -1);
    send_crc(0);
    wait_drain();
    chk("t2_sector_done_count", 64'(sd_cnt), 64'd2);

    // Test 3: six sectors span a full 1280-pixel frame wrap.
    for (int s = 0; s < 6; s++) send_sector(10 + s, 0, -1);
    wait_drain();
    chk("t3_raster", {pix_x, pix_y}, {9'd128, 8'd2});
    chk("t3_frame_starts", 64'(fs_cnt), 64'd2);
    chk("t3_sector_done_count", 64'(sd_cnt), 64'd8);

    // Test 4: stray sector_start mid-data is ignored; exactly 256 pixels, no CRC leakage.
    rd0 = exp_rd;
    send_sector(7, 0, 100);
    wait_drain();
    chk("t4_pixel_count", 64'(exp_rd - rd0), 64'd256);
    chk("t4_raster", {pix_x, pix_y}, {9'd64, 8'd3});
    send_byte(8'hFF, 1'b0, 0);
    chk("t4_idle_poll", {byte_ready, pix_valid}, {1'b1, 1'b0});
    chk("t4_sector_done_count", 64'(sd_cnt), 64'd9);

    // Test 5: reset with a hi byte held and a pixel queued.
    send_byte(8'hFE, 1'b1, 0);
    send_data(5, 0, 97, 0, -1);
    wait_drain();
    pr_mode = 0;
    @(posedge clock_50r); #1;
    send_data(5, 98, 100, 0, -1);
    chk("t5_pre_reset", {pix_valid, pix_data}, {1'b1, pat(5, 98), pat(5, 99)});
    reset = 1'b1;
    #1;
    chk("t5_in_reset", {pix_valid, byte_ready, pix_data, pix_x, pix_y, frame_start},
        {1'b0, 1'b1, 16'h0000, 9'd0, 8'd0, 1'b0});
    @(posedge clock_50r); #1;
    reset = 1'b0;
    @(posedge clock_50r); #1;
    send_byte(8'hFF, 1'b0, 0);
    send_byte(8'hFE, 1'b1, 0);
    send_data(6, 0, 1, 0, -1);
    chk("t5_first_pixel", {pix_valid, pix_data, pix_x, pix_y, frame_start},
        {1'b1, pat(6, 0), pat(6, 1), 9'd0, 8'd0, 1'b1});
    pr_mode = 1;
    send_data(6, 2, 511, 0, -1);
    send_crc(0);
    wait_drain();
    chk("t5_raster", {pix_x, pix_y}, {9'd256, 8'd0});
    chk("t5_sector_done_count", 64'(sd_cnt), 64'd10);

    // Test 6: random input gaps and random consumer stalls over four sectors.
    rd0 = exp_rd;
    pr_mode = 2;
    for (int s = 0; s < 4; s++) send_sector(20 + s, 3, -1);
    wait_drain();
    chk("t6_pixel_count", 64'(exp_rd - rd0), 64'd1024);
    chk("t6_raster_wrap", {pix_x, pix_y, frame_start}, {9'd0, 8'd0, 1'b0});
    chk("t6_frame_starts", 64'(fs_cnt), 64'd3);
    chk("t6_sector_done_count", 64'(sd_cnt), 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
